// File: rtl/rv_test_pkg.sv
// Shared types for the rv_test_ctrl slice: FSM state encoding and check-slot record.
package rv_test_pkg;

    localparam int unsigned MAX_XLEN = 64;

    typedef enum logic [1:0] {
        IDLE,
        RST,
        RUN,
        DONE
    } state_t;

    // expected is stored zero-extended so one record type serves any XLEN <= MAX_XLEN
    typedef struct packed {
        logic                valid;
        logic [4:0]          rd;
        logic [MAX_XLEN-1:0] expected;
    } chk_slot_t;

endpackage

// File: rtl/rv_chk_slot.sv
// One expected-value check slot: holds its configuration, shadows the CPU write-back
// to its register and flags a mismatch against the value the slot will hold next cycle.
module rv_chk_slot
    import rv_test_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic [4:0]      cfg_rd,
    input  logic [XLEN-1:0] cfg_val,
    input  logic            clear,
    input  logic            capture,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            mismatch
);

    chk_slot_t           slot;
    logic [XLEN-1:0]     shadow;
    logic [XLEN-1:0]     cur;
    logic [MAX_XLEN-1:0] exp_eff;
    logic                hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot   <= '0;
            shadow <= '0;
        end else begin
            if (cfg_we) begin
                slot <= '{valid: 1'b1, rd: cfg_rd, expected: MAX_XLEN'(cfg_val)};
            end
            if (clear) begin
                shadow <= '0;
            end else if (hit) begin
                shadow <= wb_data;
            end
        end
    end

    // Compare the post-capture value so a write-back on the halt cycle is judged too
    always_comb begin
        hit      = capture && wb_en && (wb_rd != 5'd0) && slot.valid && (wb_rd == slot.rd);
        cur      = hit ? wb_data : shadow;
        exp_eff  = (slot.rd == 5'd0) ? '0 : slot.expected;
        mismatch = slot.valid && (MAX_XLEN'(cur) != exp_eff);
    end

endmodule

// File: rtl/rv_test_ctrl.sv
// Test sequencer for a RISC-V core: resets the CPU, runs it to halt_pc or a watchdog limit,
// then checks register write-backs. Define RV_TEST_CTRL_PERF_EN to expose the cycle/retire counters.
module rv_test_ctrl
    import rv_test_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NUM_CHK    = 8,
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 100,
    localparam int unsigned IDX_W     = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [XLEN-1:0]    halt_pc,
    input  logic [XLEN-1:0]    pc,
    input  logic               wb_en,
    input  logic [4:0]         wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [4:0]         cfg_rd,
    input  logic [XLEN-1:0]    cfg_val,
    output logic               cpu_reset,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [NUM_CHK-1:0] fail_mask,
    output logic               timeout,
    output logic [31:0]        cycle_cnt,
    output logic [31:0]        retired_cnt
);

    localparam logic [31:0] RST_LAST = 32'(RST_CYCLES - 1);
    localparam logic [31:0] TO_LAST  = 32'(TIMEOUT - 1);

    state_t               state_q, state_d;
    logic [31:0]          rst_cnt_q;
    logic [31:0]          cyc_q;
    logic                 go, finish, halt_hit, wd_hit, cfg_ok, in_run;
    logic [NUM_CHK-1:0]   mism;
    logic                 done_q, pass_q, timeout_q;
    logic [NUM_CHK-1:0]   fail_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        go       = 1'b0;
        finish   = 1'b0;
        halt_hit = 1'b0;
        wd_hit   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RST;
                    go      = 1'b1;
                end
            end
            RST: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                halt_hit = (pc == halt_pc);
                wd_hit   = (cyc_q == TO_LAST);
                if (halt_hit || wd_hit) begin
                    state_d = DONE;
                    finish  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cfg_ok    = (state_q == IDLE) || (state_q == DONE);
    assign in_run    = (state_q == RUN);
    // IDLE is only reachable through reset, so the CPU stays held there until the first start
    assign cpu_reset = (state_q == IDLE) || (state_q == RST);
    assign busy      = (state_q == RST) || (state_q == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_cnt_q <= '0;
            cyc_q     <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            fail_q    <= '0;
        end else begin
            if (go) begin
                rst_cnt_q <= '0;
                cyc_q     <= '0;
                done_q    <= 1'b0;
                pass_q    <= 1'b0;
                timeout_q <= 1'b0;
                fail_q    <= '0;
            end else begin
                if (state_q == RST) begin
                    rst_cnt_q <= rst_cnt_q + 32'd1;
                end
                if (in_run && (cyc_q != '1)) begin
                    cyc_q <= cyc_q + 32'd1;
                end
                if (finish) begin
                    done_q    <= 1'b1;
                    timeout_q <= !halt_hit;
                    fail_q    <= mism;
                    pass_q    <= halt_hit && (mism == '0);
                end
            end
        end
    end

    assign done      = done_q;
    assign pass      = pass_q;
    assign timeout   = timeout_q;
    assign fail_mask = fail_q;

`ifdef RV_TEST_CTRL_PERF_EN
    logic [31:0] ret_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ret_q <= '0;
        end else if (go) begin
            ret_q <= '0;
        end else if (in_run && wb_en && (wb_rd != 5'd0) && (ret_q != '1)) begin
            ret_q <= ret_q + 32'd1;
        end
    end

    assign cycle_cnt   = cyc_q;
    assign retired_cnt = ret_q;
`else
    assign cycle_cnt   = '0;
    assign retired_cnt = '0;
`endif

    for (genvar i = 0; i < NUM_CHK; i++) begin : g_slot
        rv_chk_slot #(
            .XLEN (XLEN)
        ) u_slot (
            .clk      (clk),
            .rst      (reset),
            .cfg_we   (cfg_ok && cfg_we && (32'(cfg_idx) == i)),
            .cfg_rd   (cfg_rd),
            .cfg_val  (cfg_val),
            .clear    (go),
            .capture  (in_run),
            .wb_en    (wb_en),
            .wb_rd    (wb_rd),
            .wb_data  (wb_data),
            .mismatch (mism[i])
        );
    end

endmodule

// File: tb/tb_rv_test_ctrl.sv
// Directed self-checking bench for rv_test_ctrl (RST_CYCLES=3, TIMEOUT=100).
module tb_rv_test_ctrl;

`ifdef RV_TEST_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] halt_pc = '0;
    logic [31:0] pc = '0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_idx = '0;
    logic [4:0]  cfg_rd = '0;
    logic [31:0] cfg_val = '0;
    logic        cpu_reset, busy, done, pass, timeout;
    logic [7:0]  fail_mask;
    logic [31:0] cycle_cnt, retired_cnt;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    rv_test_ctrl #(
        .XLEN       (32),
        .NUM_CHK    (8),
        .RST_CYCLES (3),
        .TIMEOUT    (100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .halt_pc     (halt_pc),
        .pc          (pc),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_rd      (cfg_rd),
        .cfg_val     (cfg_val),
        .cpu_reset   (cpu_reset),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .fail_mask   (fail_mask),
        .timeout     (timeout),
        .cycle_cnt   (cycle_cnt),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pv(input logic [63:0] v);
        return PERF ? v : 64'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        start   = 1'b0;
        wb_en   = 1'b0;
        wb_rd   = '0;
        wb_data = '0;
        cfg_we  = 1'b0;
    endtask

    task automatic cfg(input logic [2:0] idx, input logic [4:0] rd, input logic [31:0] val);
        cfg_we  = 1'b1;
        cfg_idx = idx;
        cfg_rd  = rd;
        cfg_val = val;
        tick();
        cfg_we  = 1'b0;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] data);
        wb_en   = 1'b1;
        wb_rd   = rd;
        wb_data = data;
    endtask

    // Pulses start and walks the reset phase; returns at the start of RUN cycle 1
    task automatic start_phase(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_rst1_cpu_reset"}, 64'(cpu_reset), 64'd1);
        chk({tag, "_rst1_done_clr"}, 64'(done), 64'd0);
        chk({tag, "_rst1_fail_clr"}, 64'(fail_mask), 64'd0);
        tick();
        chk({tag, "_rst2_cpu_reset"}, 64'(cpu_reset), 64'd1);
        tick();
        chk({tag, "_rst3_cpu_reset"}, 64'(cpu_reset), 64'd1);
        tick();
        chk({tag, "_run_cpu_reset"}, 64'(cpu_reset), 64'd0);
        chk({tag, "_run_busy"}, 64'(busy), 64'd1);
    endtask

    initial begin
        // Reset state
        #1 reset = 1'b1;
        #1;
        chk("rst_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_pass", 64'(pass), 64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);
        chk("rst_fail_mask", 64'(fail_mask), 64'd0);
        chk("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
        chk("rst_retired_cnt", 64'(retired_cnt), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("idle_cpu_reset_held", 64'(cpu_reset), 64'd1);

        // A: passing run, halt at RUN cycle 20, late x22 write on the halt cycle, start ignored
        cfg(3'd0, 5'd13, 32'd105);
        cfg(3'd1, 5'd22, 32'd83);
        halt_pc = 32'h100;
        start_phase("A");
        for (int k = 1; k <= 20; k++) begin
            quiet();
            pc = 32'h1000 + 32'(k) * 32'd4;
            if (k == 3)  wb(5'd13, 32'd105);
            if (k == 7)  wb(5'd0, 32'd7);
            if (k == 10) start = 1'b1;
            if (k == 20) begin
                wb(5'd22, 32'd83);
                pc = halt_pc;
            end
            tick();
            if (k == 10) begin
                chk("A_start_ignored_busy", 64'(busy), 64'd1);
                chk("A_start_ignored_cpu_reset", 64'(cpu_reset), 64'd0);
                chk("A_cycle_cnt_mid", 64'(cycle_cnt), pv(64'd10));
            end
        end
        quiet();
        pc = '0;
        chk("A_done", 64'(done), 64'd1);
        chk("A_pass", 64'(pass), 64'd1);
        chk("A_fail_mask", 64'(fail_mask), 64'd0);
        chk("A_timeout", 64'(timeout), 64'd0);
        chk("A_busy", 64'(busy), 64'd0);
        chk("A_cpu_reset", 64'(cpu_reset), 64'd0);
        chk("A_cycle_cnt", 64'(cycle_cnt), pv(64'd20));
        chk("A_retired_cnt", 64'(retired_cnt), pv(64'd2));
        tick();
        tick();
        chk("A_done_sticky", 64'(done), 64'd1);
        chk("A_pass_sticky", 64'(pass), 64'd1);

        // B: mismatch on slot0 x5; cfg write during RUN must be ignored
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cfg(3'd0, 5'd5, 32'hFFFF_FFEA);
        start_phase("B");
        for (int k = 1; k <= 4; k++) begin
            quiet();
            pc = 32'h1000;
            if (k == 1) begin
                cfg_we  = 1'b1;
                cfg_idx = 3'd3;
                cfg_rd  = 5'd7;
                cfg_val = 32'd1;
            end
            if (k == 2) wb(5'd5, 32'hFFFF_FFE0);
            if (k == 4) pc = halt_pc;
            tick();
        end
        quiet();
        chk("B_done", 64'(done), 64'd1);
        chk("B_pass", 64'(pass), 64'd0);
        chk("B_fail_mask", 64'(fail_mask), 64'h01);
        chk("B_timeout", 64'(timeout), 64'd0);
        chk("B_cycle_cnt", 64'(cycle_cnt), pv(64'd4));
        chk("B_retired_cnt", 64'(retired_cnt), pv(64'd1));

        // C: pc never reaches halt_pc, watchdog fires on RUN cycle 100
        halt_pc = 32'hFFFF_FFFC;
        start_phase("C");
        for (int k = 1; k <= 100; k++) begin
            quiet();
            pc = 32'(k) * 32'd4;
            if (k == 2) wb(5'd5, 32'hFFFF_FFEA);
            tick();
            if (k == 99) begin
                chk("C_not_done_99", 64'(done), 64'd0);
                chk("C_busy_99", 64'(busy), 64'd1);
            end
        end
        quiet();
        chk("C_done", 64'(done), 64'd1);
        chk("C_timeout", 64'(timeout), 64'd1);
        chk("C_pass", 64'(pass), 64'd0);
        chk("C_fail_mask", 64'(fail_mask), 64'd0);
        chk("C_cycle_cnt", 64'(cycle_cnt), pv(64'd100));

        // D: x0 slot with a write to x0, halt coincides with watchdog
        cfg(3'd1, 5'd0, 32'd0);
        halt_pc = 32'h200;
        start_phase("D");
        for (int k = 1; k <= 100; k++) begin
            quiet();
            pc = 32'h4000;
            if (k == 2)   wb(5'd5, 32'hFFFF_FFEA);
            if (k == 50)  wb(5'd0, 32'd7);
            if (k == 100) pc = halt_pc;
            tick();
        end
        quiet();
        chk("D_done", 64'(done), 64'd1);
        chk("D_pass", 64'(pass), 64'd1);
        chk("D_timeout", 64'(timeout), 64'd0);
        chk("D_fail_mask", 64'(fail_mask), 64'd0);
        chk("D_cycle_cnt", 64'(cycle_cnt), pv(64'd100));
        chk("D_retired_cnt", 64'(retired_cnt), pv(64'd1));

        // E: reset mid-RUN aborts and clears the slot configuration
        start_phase("E");
        pc = 32'h4000;
        for (int k = 1; k <= 10; k++) tick();
        #2 reset = 1'b1;
        #1;
        chk("E_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("E_busy", 64'(busy), 64'd0);
        chk("E_done", 64'(done), 64'd0);
        chk("E_pass", 64'(pass), 64'd0);
        chk("E_timeout", 64'(timeout), 64'd0);
        chk("E_cycle_cnt", 64'(cycle_cnt), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("E_idle_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("E_idle_no_done", 64'(done), 64'd0);
        halt_pc = 32'h300;
        start_phase("E2");
        quiet();
        pc = halt_pc;
        wb(5'd13, 32'd1);
        tick();
        quiet();
        chk("E2_done", 64'(done), 64'd1);
        chk("E2_pass_slots_cleared", 64'(pass), 64'd1);
        chk("E2_fail_mask", 64'(fail_mask), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
